// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: captures a hex value and rewrites one 7-segment digit
// register per clock, most significant digit first. Leading-zero blanking
// is optional per update. Segment outputs are active-low, bit 0 = a.
// Optional feature macro: BLINK_EN (flashes the display while blink is high).
//
// state | meaning
// IDLE  | waiting for load
// SCAN  | writing digit idx each edge, busy=1
// DONE  | update finished, done=1 for this cycle
module hex_display_ctrl #(
  parameter int NDIGITS   = 4,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic                   load,
  input  logic                   blank_lz,
  input  logic                   blink,
  output logic [7*NDIGITS-1:0]   hex,
  output logic                   busy,
  output logic                   done
);

  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                 state;
  logic [4*NDIGITS-1:0]   cap;
  logic [IW-1:0]          idx;
  logic                   lz;
  logic [7*NDIGITS-1:0]   digits;
  logic [3:0]             nib;
  logic [6:0]             nib_seg;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  // nibble of the captured value currently being written and its decode
  always_comb begin
    nib     = cap[int'(idx)*4 +: 4];
    nib_seg = seg7(nib);
  end

  // sequencing FSM: capture on load, one digit per SCAN edge, registered busy/done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cap    <= '0;
      idx    <= IW'(NDIGITS - 1);
      lz     <= 1'b0;
      digits <= '1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (load) begin
            cap   <= value;
            idx   <= IW'(NDIGITS - 1);
            lz    <= blank_lz;
            busy  <= 1'b1;
            state <= SCAN;
          end else begin
            state <= IDLE;
          end
        end
        SCAN: begin
          // digit 0 is always decoded so a zero value still shows "0"
          if (idx != '0 && lz && nib == 4'h0) begin
            digits[int'(idx)*7 +: 7] <= 7'h7F;
          end else begin
            digits[int'(idx)*7 +: 7] <= nib_seg;
            lz <= 1'b0;
          end
          if (idx == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef BLINK_EN
  localparam int PW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic [PW-1:0] pre;
  logic          phase;

  // free-running blink prescaler; phase flips every BLINK_DIV cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre   <= '0;
      phase <= 1'b0;
    end else if (pre == PW'(BLINK_DIV - 1)) begin
      pre   <= '0;
      phase <= ~phase;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // blanking is applied only at the output so digit registers stay intact
  always_comb hex = (blink && phase) ? '1 : digits;
`else
  logic unused_blink;

  // blink is kept on the port but has no effect in this build
  always_comb begin
    unused_blink = blink;
    hex          = digits;
  end
`endif

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl (NDIGITS=4, BLINK_DIV=4).
// Reference model: a queue of pending digit writes computed from the
// leading-zero rule, segment letters decoded from text, blink phase
// derived from the edge count since reset.
module tb_hex_display_ctrl;
  localparam int ND = 4;
  localparam int BD = 4;

  logic        clk = 1'b0;
  logic        clk_run = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic        blink = 1'b0;
  logic [27:0] hex;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  hex_display_ctrl #(.NDIGITS(ND), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .blank_lz(blank_lz),
    .blink(blink), .hex(hex), .busy(busy), .done(done)
  );

  always #5 if (clk_run) clk = ~clk;

  // ---------------- reference model ----------------
  string seg_names [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                            "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                            "cdefg", "adef", "bcdeg", "adefg", "aefg"};
  logic [6:0]  m_dig [ND];
  logic [10:0] pend [$];
  logic        m_done;
  int          n_edges;

  function automatic logic [6:0] ref_seg(input int d);
    logic [6:0] m = 7'h7F;
    string s = seg_names[d];
    for (int j = 0; j < s.len(); j++) m[int'(s[j]) - 97] = 1'b0;
    return m;
  endfunction

  task automatic model_reset();
    pend.delete();
    for (int i = 0; i < ND; i++) m_dig[i] = 7'h7F;
    m_done = 1'b0;
    n_edges = 0;
  endtask

  task automatic model_edge();
    logic       lz;
    logic [3:0] nib;
    logic [6:0] seg;
    logic [10:0] e;
    n_edges++;
    if (pend.size() > 0) begin
      e = pend.pop_front();
      m_dig[e[10:7]] = e[6:0];
      m_done = (pend.size() == 0);
    end else begin
      m_done = 1'b0;
      if (load) begin
        lz = blank_lz;
        for (int i = ND - 1; i >= 0; i--) begin
          nib = value[i*4 +: 4];
          if (i > 0 && lz && nib == 4'h0) seg = 7'h7F;
          else begin
            seg = ref_seg(int'(nib));
            lz = 1'b0;
          end
          pend.push_back({4'(i), seg});
        end
      end
    end
  endtask

  function automatic logic m_busy();
    return pend.size() != 0;
  endfunction

  function automatic logic [27:0] exp_hex();
    logic [27:0] h;
    for (int i = 0; i < ND; i++) h[i*7 +: 7] = m_dig[i];
`ifdef BLINK_EN
    if (blink && ((n_edges / BD) % 2 == 1)) h = '1;
`endif
    return h;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (hex !== 28'hFFFFFFF) begin
      failures++; $display("FAIL reset_hex got=%h exp=%h", hex, 28'hFFFFFFF);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    #1 rst = 1'b0;
    model_reset();
    clk_run = 1'b1;
  endtask

  task automatic test_basic();
    int nb = 0, nd = 0;
    value = 16'h1234; blank_lz = 1'b0; blink = 1'b0;
    for (int k = 0; k < 6; k++) begin
      load = (k == 0);
      tick();
      if (k == 0) begin
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL first_load_busy got=%b exp=1", busy); end
      end
      nb += int'(busy); nd += int'(done);
      checks++;
      if ({busy, done, hex} !== {m_busy(), m_done, exp_hex()}) begin
        failures++;
        $display("FAIL basic k=%0d got b/d/hex=%b/%b/%h exp=%b/%b/%h", k, busy, done, hex,
                 m_busy(), m_done, exp_hex());
      end
    end
    load = 1'b0;
    checks++;
    if (hex !== {7'h79, 7'h24, 7'h30, 7'h19}) begin
      failures++; $display("FAIL basic_1234 got=%h exp=%h", hex, {7'h79, 7'h24, 7'h30, 7'h19});
    end
    checks++;
    if (nb != 4 || nd != 1) begin
      failures++; $display("FAIL basic_counts got busy=%0d done=%0d exp busy=4 done=1", nb, nd);
    end
  endtask

  task automatic test_lz();
    logic [15:0] vals [2] = '{16'h00A0, 16'h0000};
    logic [27:0] lits [2] = '{{7'h7F, 7'h7F, 7'h08, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    blank_lz = 1'b1; blink = 1'b0;
    for (int t = 0; t < 2; t++) begin
      value = vals[t];
      for (int k = 0; k < 6; k++) begin
        load = (k == 0);
        tick();
        checks++;
        if ({busy, done, hex} !== {m_busy(), m_done, exp_hex()}) begin
          failures++;
          $display("FAIL lz v=%h k=%0d got b/d/hex=%b/%b/%h exp=%b/%b/%h", vals[t], k, busy, done,
                   hex, m_busy(), m_done, exp_hex());
        end
      end
      load = 1'b0;
      checks++;
      if (hex !== lits[t]) begin
        failures++; $display("FAIL lz_final v=%h got=%h exp=%h", vals[t], hex, lits[t]);
      end
    end
  endtask

  task automatic test_handshake();
    blank_lz = 1'b0; blink = 1'b0;
    for (int k = 0; k < 11; k++) begin
      load = (k == 0 || k == 2 || k == 5);
      value = (k == 0) ? 16'h1234 : (k == 2) ? 16'hFFFF : (k == 5) ? 16'h5A0C : value;
      tick();
      checks++;
      if ({busy, done, hex} !== {m_busy(), m_done, exp_hex()}) begin
        failures++;
        $display("FAIL handshake k=%0d got b/d/hex=%b/%b/%h exp=%b/%b/%h", k, busy, done, hex,
                 m_busy(), m_done, exp_hex());
      end
      if (k == 4) begin
        checks++;
        if (hex !== {7'h79, 7'h24, 7'h30, 7'h19} || done !== 1'b1) begin
          failures++; $display("FAIL scan_load_ignored got hex=%h done=%b exp hex=%h done=1", hex, done,
                               {7'h79, 7'h24, 7'h30, 7'h19});
        end
      end
      if (k == 5) begin
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL done_reload_busy got=%b exp=1", busy); end
      end
    end
    load = 1'b0;
  endtask

  task automatic test_reset_mid();
    int nd = 0;
    blank_lz = 1'b0; blink = 1'b0;
    value = 16'h8765;
    for (int k = 0; k < 3; k++) begin
      load = (k == 0);
      tick();
    end
    load = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, hex} !== {1'b0, 1'b0, 28'hFFFFFFF}) begin
      failures++; $display("FAIL reset_mid got b/d/hex=%b/%b/%h exp=0/0/fffffff", busy, done, hex);
    end
    #1 rst = 1'b0;
    model_reset();
    for (int k = 0; k < 8; k++) begin
      tick();
      nd += int'(done);
      checks++;
      if ({busy, done, hex} !== {m_busy(), m_done, exp_hex()}) begin
        failures++;
        $display("FAIL reset_mid_after k=%0d got b/d/hex=%b/%b/%h exp=%b/%b/%h", k, busy, done, hex,
                 m_busy(), m_done, exp_hex());
      end
    end
    checks++;
    if (nd != 0) begin failures++; $display("FAIL reset_mid_done got=%0d pulses exp=0", nd); end
  endtask

  task automatic test_blink();
    blank_lz = 1'b0; blink = 1'b0; value = 16'h1234;
    for (int k = 0; k < 6; k++) begin
      load = (k == 0);
      tick();
    end
    load = 1'b0;
    for (int k = 0; k < 24; k++) begin
      blink = (k < 16);
      tick();
      checks++;
      if ({busy, done, hex} !== {m_busy(), m_done, exp_hex()}) begin
        failures++;
        $display("FAIL blink k=%0d blink=%b got b/d/hex=%b/%b/%h exp=%b/%b/%h", k, blink, busy, done,
                 hex, m_busy(), m_done, exp_hex());
      end
    end
    blink = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      load = ($urandom_range(0, 2) == 0);
      value = 16'($urandom);
      if ($urandom_range(0, 1) == 0) value[15:8] = 8'h00;
      if ($urandom_range(0, 2) == 0) value[7:4] = 4'h0;
      blank_lz = 1'($urandom);
      blink = 1'($urandom);
      tick();
      checks++;
      if ({busy, done, hex} !== {m_busy(), m_done, exp_hex()}) begin
        failures++;
        $display("FAIL random k=%0d got b/d/hex=%b/%b/%h exp=%b/%b/%h", k, busy, done, hex,
                 m_busy(), m_done, exp_hex());
      end
    end
    load = 1'b0; blink = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_lz();
    test_handshake();
    test_reset_mid();
    test_blink();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
